// File: rtl/mdu_pkg.sv
// Shared types for the MDU issue arbiter: funct3 operation codes, operand formats and FSM states.
// Pure declarations; no logic or latency of its own.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  localparam logic [1:0] MDU_FMT_W = 2'b00;
  localparam logic [1:0] MDU_FMT_D = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first request at or after ptr_i, wrapping.
// Zero latency; no backpressure, the caller decides whether the grant is used.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  function automatic int wrap_idx(input logic [IW-1:0] ptr, input int off);
    return (int'(ptr) + off) % NUM_REQ;
  endfunction

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!any_o && req_i[wrap_idx(ptr_i, off)]) begin
        any_o                       = 1'b1;
        gnt_o[wrap_idx(ptr_i, off)] = 1'b1;
        idx_o                       = IW'(wrap_idx(ptr_i, off));
      end
    end
  end

endmodule

// File: rtl/mdu_issue_arbiter.sv
// Shares one MDU between NUM_REQ requesters: accept, start pulse, wait for done/timeout, tagged response.
// Accept at T, start at T+1, response one cycle after done; req_ready only in IDLE, so one op in flight.
module mdu_issue_arbiter
  import mdu_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*3-1:0]          req_op,
  input  logic [NUM_REQ*2-1:0]          req_fmt,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*5-1:0]          req_rd,
  input  logic [NUM_REQ-1:0]            flush,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [4:0]                    resp_rd,
  output logic                          resp_exc,
  output logic                          resp_timeout,
  output logic                          mdu_start,
  output logic [2:0]                    mdu_op,
  output logic [1:0]                    mdu_fmt,
  output logic [DATA_WIDTH-1:0]         mdu_a,
  output logic [DATA_WIDTH-1:0]         mdu_b,
  input  logic                          mdu_done,
  input  logic [DATA_WIDTH-1:0]         mdu_result,
  input  logic                          mdu_exception
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  arb_state_e            state_q;
  logic [IW-1:0]         rr_ptr_q;
  logic [IW-1:0]         owner_q;
  logic                  killed_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  start_q;
  logic [2:0]            op_q;
  logic [1:0]            fmt_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [4:0]            rd_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [4:0]            rrd_q;
  logic                  rexc_q;
  logic                  rto_q;

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;
  logic [IW-1:0]         ptr_after;
  logic                  owner_flush;
  logic                  timeout_hit;

  logic [2:0]            sel_op;
  logic [1:0]            sel_fmt;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [4:0]            sel_rd;

  // A requester flushing in the same cycle it is valid is not eligible.
  assign eligible = req_valid & ~flush;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_rr (
    .req_i(eligible),
    .ptr_i(rr_ptr_q),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx),
    .any_o(arb_any)
  );

  assign req_ready   = (!rst && state_q == ST_IDLE) ? arb_gnt : '0;
  assign ptr_after   = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
  assign owner_flush = flush[owner_q];

  // cnt_d is the value the counter reaches this WAIT cycle; hitting the limit ends the wait.
  assign cnt_d       = cnt_q + CW'(1);
  assign timeout_hit = (cnt_d == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    sel_op  = '0;
    sel_fmt = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_rd  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_op  = req_op[i*3 +: 3];
        sel_fmt = req_fmt[i*2 +: 2];
        sel_a   = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b   = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        sel_rd  = req_rd[i*5 +: 5];
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    if (!rst && state_q == ST_RESP && !killed_q && !owner_flush) begin
      resp_valid[owner_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      killed_q <= 1'b0;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      op_q     <= '0;
      fmt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      rdata_q  <= '0;
      rrd_q    <= '0;
      rexc_q   <= 1'b0;
      rto_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            owner_q  <= arb_idx;
            rr_ptr_q <= ptr_after;
            op_q     <= sel_op;
            fmt_q    <= sel_fmt;
            a_q      <= sel_a;
            b_q      <= sel_b;
            rd_q     <= sel_rd;
            killed_q <= 1'b0;
            start_q  <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
          if (owner_flush) killed_q <= 1'b1;
        end
        ST_WAIT: begin
          cnt_q <= cnt_d;
          if (owner_flush) killed_q <= 1'b1;
          // The MDU keeps running after a flush; only the response is suppressed.
          if (mdu_done) begin
            rdata_q <= mdu_result;
            rexc_q  <= mdu_exception;
            rto_q   <= 1'b0;
            rrd_q   <= rd_q;
            state_q <= ST_RESP;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            rexc_q  <= 1'b1;
            rto_q   <= 1'b1;
            rrd_q   <= rd_q;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mdu_start    = start_q;
  assign mdu_op       = op_q;
  assign mdu_fmt      = fmt_q;
  assign mdu_a        = a_q;
  assign mdu_b        = b_q;
  assign resp_data    = rdata_q;
  assign resp_rd      = rrd_q;
  assign resp_exc     = rexc_q;
  assign resp_timeout = rto_q;

endmodule

// File: tb/tb_mdu_issue_arbiter.sv
// Bench for mdu_issue_arbiter: directed scenarios plus randomized transactions against a timeline model.
module tb_mdu_issue_arbiter;
  import mdu_pkg::*;

  localparam int NR = 2;
  localparam int DW = 64;
  localparam int TO = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*3-1:0] req_op;
  logic [NR*2-1:0] req_fmt;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR*5-1:0] req_rd;
  logic [NR-1:0]   flush = '0;
  logic [NR-1:0]   resp_valid;
  logic [DW-1:0]   resp_data;
  logic [4:0]      resp_rd;
  logic            resp_exc;
  logic            resp_timeout;
  logic            mdu_start;
  logic [2:0]      mdu_op;
  logic [1:0]      mdu_fmt;
  logic [DW-1:0]   mdu_a;
  logic [DW-1:0]   mdu_b;
  logic            mdu_done = 1'b0;
  logic [DW-1:0]   mdu_result = '0;
  logic            mdu_exception = 1'b0;

  logic [2:0]  op_s  [NR];
  logic [1:0]  fmt_s [NR];
  logic [63:0] a_s   [NR];
  logic [63:0] b_s   [NR];
  logic [4:0]  rd_s  [NR];

  int checks = 0;
  int errors = 0;
  int mptr = 0;

  logic [NR-1:0] obs_rdy;
  logic [NR-1:0] obs_vec;
  int            obs_start_c, obs_starts, obs_resp_c, obs_resps, obs_next_c;
  logic [2:0]    obs_op;
  logic [1:0]    obs_fmt;
  logic [63:0]   obs_a, obs_b, obs_data;
  logic [4:0]    obs_rd;
  logic          obs_exc, obs_to;

  mdu_issue_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_fmt(req_fmt), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .flush(flush), .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_exc(resp_exc), .resp_timeout(resp_timeout), .mdu_start(mdu_start),
    .mdu_op(mdu_op), .mdu_fmt(mdu_fmt), .mdu_a(mdu_a), .mdu_b(mdu_b),
    .mdu_done(mdu_done), .mdu_result(mdu_result), .mdu_exception(mdu_exception)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_op = '0; req_fmt = '0; req_a = '0; req_b = '0; req_rd = '0;
    for (int i = 0; i < NR; i++) begin
      req_op[i*3 +: 3]   = op_s[i];
      req_fmt[i*2 +: 2]  = fmt_s[i];
      req_a[i*DW +: DW]  = a_s[i];
      req_b[i*DW +: DW]  = b_s[i];
      req_rd[i*5 +: 5]   = rd_s[i];
    end
  end

  // Reference round-robin rule: first eligible index at or after ptr, modulo NR.
  function automatic int rr_pick(input logic [NR-1:0] elig, input int ptr);
    for (int off = 0; off < NR; off++)
      if (elig[(ptr + off) % NR]) return (ptr + off) % NR;
    return -1;
  endfunction

  // Drives one transaction (offer at c=0) and records what the DUT does over the next 36 cycles.
  task automatic do_txn(input logic [NR-1:0] vld, input int k, input int fl_at,
                        input logic [63:0] res, input logic exc, input bit hold);
    int own;
    @(negedge clk);
    req_valid = vld; flush = '0; mdu_done = 1'b0;
    #1 obs_rdy = req_ready;
    own = obs_rdy[1] ? 1 : 0;
    obs_start_c = -1; obs_starts = 0; obs_resp_c = -1; obs_resps = 0; obs_next_c = -1;
    obs_vec = '0; obs_data = '0; obs_rd = '0; obs_exc = 1'b0; obs_to = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (!hold || obs_next_c >= 0) req_valid = '0;
      mdu_done = (c == k + 1); mdu_result = res; mdu_exception = exc;
      flush = '0;
      if (c == fl_at) flush[own] = 1'b1;
      #1;
      if (mdu_start) begin obs_starts++; if (obs_start_c < 0) obs_start_c = c; end
      if (c == 1) begin obs_op = mdu_op; obs_fmt = mdu_fmt; obs_a = mdu_a; obs_b = mdu_b; end
      if (resp_valid != '0) begin
        obs_resps++;
        if (obs_resp_c < 0) begin
          obs_resp_c = c; obs_vec = resp_valid; obs_data = resp_data;
          obs_rd = resp_rd; obs_exc = resp_exc; obs_to = resp_timeout;
        end
      end
      if (hold && obs_next_c < 0 && req_ready != '0) begin obs_next_c = c; req_valid = '0; end
    end
    @(negedge clk);
    mdu_done = 1'b0; flush = '0; req_valid = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 2'b11; mdu_done = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b exp 00", resp_valid); end
    checks++; if (mdu_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", mdu_start); end
    checks++; if ({mdu_op, mdu_fmt, mdu_a, mdu_b} !== '0) begin errors++; $display("FAIL reset_mdu_bus got op=%0h fmt=%0h a=%0h b=%0h exp 0", mdu_op, mdu_fmt, mdu_a, mdu_b); end
    checks++; if ({resp_data, resp_rd, resp_exc, resp_timeout} !== '0) begin errors++; $display("FAIL reset_resp_fields got d=%0h rd=%0d e=%b t=%b exp 0", resp_data, resp_rd, resp_exc, resp_timeout); end
    @(negedge clk);
    rst = 1'b0; mdu_done = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b exp 01", req_ready); end
    req_valid = '0;
    mptr = 0;
  endtask

  task automatic test_single;
    op_s[0] = MDU_MUL; fmt_s[0] = MDU_FMT_D; a_s[0] = 64'd6; b_s[0] = 64'd7; rd_s[0] = 5'd5;
    op_s[1] = MDU_REM; fmt_s[1] = MDU_FMT_W; a_s[1] = 64'd99; b_s[1] = 64'd4; rd_s[1] = 5'd20;
    do_txn(2'b01, 3, -1, 64'd42, 1'b0, 1'b0);
    checks++; if (obs_rdy !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", obs_rdy); end
    checks++; if (obs_start_c != 1 || obs_starts != 1) begin errors++; $display("FAIL single_start got c=%0d n=%0d exp c=1 n=1", obs_start_c, obs_starts); end
    checks++; if (obs_a !== 64'd6 || obs_b !== 64'd7 || obs_op !== 3'd0 || obs_fmt !== 2'b01) begin errors++; $display("FAIL single_latch got op=%0d fmt=%b a=%0d b=%0d exp 0 01 6 7", obs_op, obs_fmt, obs_a, obs_b); end
    checks++; if (obs_resp_c != 5 || obs_resps != 1) begin errors++; $display("FAIL single_resp_time got c=%0d n=%0d exp c=5 n=1", obs_resp_c, obs_resps); end
    checks++; if (obs_vec !== 2'b01) begin errors++; $display("FAIL single_resp_vec got %b exp 01", obs_vec); end
    checks++; if (obs_data !== 64'd42 || obs_rd !== 5'd5) begin errors++; $display("FAIL single_resp_data got d=%0d rd=%0d exp 42 5", obs_data, obs_rd); end
    checks++; if (obs_exc !== 1'b0 || obs_to !== 1'b0) begin errors++; $display("FAIL single_resp_flags got e=%b t=%b exp 0 0", obs_exc, obs_to); end
    checks++; if (resp_data !== 64'd42) begin errors++; $display("FAIL single_resp_hold got %0d exp 42", resp_data); end
    mptr = 1;
  endtask

  task automatic test_round_robin;
    int exp_g;
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < NR; r++) begin
        a_s[r] = {$urandom, $urandom}; rd_s[r] = 5'(10 + 4*t + r);
      end
      exp_g = rr_pick(2'b11, mptr);
      do_txn(2'b11, 2, -1, 64'(t), 1'b0, 1'b0);
      checks++; if (obs_rdy !== 2'(1 << exp_g)) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", t, obs_rdy, 2'(1 << exp_g)); end
      checks++; if (obs_vec !== 2'(1 << exp_g) || obs_rd !== rd_s[exp_g] || obs_a !== a_s[exp_g]) begin errors++; $display("FAIL rr_owner%0d got vec=%b rd=%0d exp vec=%b rd=%0d", t, obs_vec, obs_rd, 2'(1 << exp_g), rd_s[exp_g]); end
      mptr = (exp_g + 1) % NR;
    end
  endtask

  task automatic test_timeout;
    do_txn(2'b01, 1000, -1, 64'hDEAD, 1'b0, 1'b0);
    checks++; if (obs_resp_c != TO + 1 || obs_resps != 1) begin errors++; $display("FAIL timeout_time got c=%0d n=%0d exp c=%0d n=1", obs_resp_c, obs_resps, TO + 1); end
    checks++; if (obs_data !== 64'd0 || obs_exc !== 1'b1 || obs_to !== 1'b1) begin errors++; $display("FAIL timeout_fields got d=%0h e=%b t=%b exp 0 1 1", obs_data, obs_exc, obs_to); end
    mptr = 1;
    // Done in the ISSUE cycle must be ignored, so this still times out.
    do_txn(2'b01, 0, -1, 64'hBEEF, 1'b0, 1'b0);
    checks++; if (obs_resp_c != TO + 1 || obs_to !== 1'b1 || obs_data !== 64'd0) begin errors++; $display("FAIL done_in_issue got c=%0d t=%b d=%0h exp c=%0d t=1 d=0", obs_resp_c, obs_to, obs_data, TO + 1); end
    mptr = 1;
  endtask

  task automatic test_flush;
    @(negedge clk);
    req_valid = 2'b01; flush = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL flush_same_req got %b exp 00", req_ready); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'(1 << rr_pick(2'b10, mptr))) begin errors++; $display("FAIL flush_masks_one got %b exp 10", req_ready); end
    req_valid = '0; flush = '0;
    op_s[1] = MDU_DIV; a_s[1] = 64'd100; b_s[1] = 64'd7; rd_s[1] = 5'd9;
    do_txn(2'b10, 16, 5, 64'd14, 1'b0, 1'b0);
    checks++; if (obs_rdy !== 2'b10 || obs_resps != 0) begin errors++; $display("FAIL flush_wait got grant=%b resps=%0d exp 10 0", obs_rdy, obs_resps); end
    mptr = 0;
    do_txn(2'b10, 2, -1, 64'd3, 1'b0, 1'b0);
    checks++; if (obs_rdy !== 2'b10 || obs_resp_c != 4 || obs_data !== 64'd3) begin errors++; $display("FAIL flush_next got grant=%b c=%0d d=%0d exp 10 4 3", obs_rdy, obs_resp_c, obs_data); end
    mptr = 0;
    do_txn(2'b01, 5, 7, 64'd8, 1'b0, 1'b0);
    checks++; if (obs_rdy !== 2'b01 || obs_resps != 0) begin errors++; $display("FAIL flush_in_resp got grant=%b resps=%0d exp 01 0", obs_rdy, obs_resps); end
    mptr = 1;
  endtask

  task automatic test_collision;
    op_s[0] = MDU_DIV; a_s[0] = 64'd5; b_s[0] = 64'd0;
    do_txn(2'b01, TO - 1, -1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    checks++; if (obs_resp_c != TO + 1) begin errors++; $display("FAIL collide_time got %0d exp %0d", obs_resp_c, TO + 1); end
    checks++; if (obs_exc !== 1'b1 || obs_to !== 1'b0 || obs_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL collide_fields got e=%b t=%b d=%0h exp 1 0 ffffffffffffffff", obs_exc, obs_to, obs_data); end
    mptr = 1;
  endtask

  task automatic test_back_to_back;
    do_txn(2'b01, 4, -1, 64'd77, 1'b0, 1'b1);
    checks++; if (obs_resp_c != 6) begin errors++; $display("FAIL b2b_resp got %0d exp 6", obs_resp_c); end
    checks++; if (obs_next_c != 7) begin errors++; $display("FAIL b2b_next_ready got %0d exp 7", obs_next_c); end
    mptr = 1;
  endtask

  task automatic test_reset_mid_wait;
    a_s[0] = 64'h1234; op_s[0] = MDU_MULHU; rd_s[0] = 5'd3;
    @(negedge clk); req_valid = 2'b01;
    @(negedge clk); req_valid = '0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if ({mdu_start, mdu_op, mdu_a, resp_valid, resp_data, resp_rd} !== '0) begin errors++; $display("FAIL rst_wait_outputs got st=%b op=%0d a=%0h rv=%b d=%0h rd=%0d exp 0", mdu_start, mdu_op, mdu_a, resp_valid, resp_data, resp_rd); end
    @(negedge clk); mdu_done = 1'b1; mdu_result = 64'h5555; mdu_exception = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (resp_valid !== 2'b00 || resp_data !== 64'd0 || resp_exc !== 1'b0) begin errors++; $display("FAIL rst_wait_stray%0d got rv=%b d=%0h e=%b exp 00 0 0", c, resp_valid, resp_data, resp_exc); end
      @(negedge clk); mdu_done = 1'b0;
    end
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10 || mdu_start !== 1'b0) begin errors++; $display("FAIL rst_wait_idle got rdy=%b st=%b exp 10 0", req_ready, mdu_start); end
    req_valid = '0;
    mptr = 0;
  endtask

  task automatic test_random;
    logic [NR-1:0] vld;
    logic [63:0]   res;
    logic          exc, done_eff, flushed;
    int            k, fl_at, exp_g, exp_rc;
    for (int t = 0; t < 25; t++) begin
      for (int r = 0; r < NR; r++) begin
        op_s[r] = 3'($urandom_range(0, 7)); fmt_s[r] = 2'($urandom_range(0, 1));
        a_s[r] = {$urandom, $urandom}; b_s[r] = {$urandom, $urandom}; rd_s[r] = 5'($urandom);
      end
      vld = 2'($urandom_range(1, 3));
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(1, 8);
      res = {$urandom, $urandom}; exc = 1'($urandom);
      done_eff = (k >= 1 && k <= TO - 1);
      exp_rc = done_eff ? k + 2 : TO + 1;
      fl_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, exp_rc + 1) : -1;
      flushed = (fl_at >= 1 && fl_at <= exp_rc);
      exp_g = rr_pick(vld, mptr);
      do_txn(vld, k, fl_at, res, exc, 1'b0);
      checks++; if (obs_rdy !== 2'(1 << exp_g)) begin errors++; $display("FAIL rand%0d_grant got %b exp %b", t, obs_rdy, 2'(1 << exp_g)); end
      checks++; if (obs_start_c != 1 || obs_starts != 1) begin errors++; $display("FAIL rand%0d_start got c=%0d n=%0d exp 1 1", t, obs_start_c, obs_starts); end
      checks++; if (obs_a !== a_s[exp_g] || obs_b !== b_s[exp_g] || obs_op !== op_s[exp_g] || obs_fmt !== fmt_s[exp_g]) begin errors++; $display("FAIL rand%0d_latch got a=%0h b=%0h op=%0d exp a=%0h b=%0h op=%0d", t, obs_a, obs_b, obs_op, a_s[exp_g], b_s[exp_g], op_s[exp_g]); end
      checks++; if (obs_resps != (flushed ? 0 : 1)) begin errors++; $display("FAIL rand%0d_resp_count got %0d exp %0d", t, obs_resps, flushed ? 0 : 1); end
      if (!flushed) begin
        checks++; if (obs_resp_c != exp_rc || obs_vec !== 2'(1 << exp_g)) begin errors++; $display("FAIL rand%0d_resp_when got c=%0d vec=%b exp c=%0d vec=%b", t, obs_resp_c, obs_vec, exp_rc, 2'(1 << exp_g)); end
        checks++; if (obs_data !== (done_eff ? res : 64'd0) || obs_rd !== rd_s[exp_g]) begin errors++; $display("FAIL rand%0d_resp_data got d=%0h rd=%0d exp d=%0h rd=%0d", t, obs_data, obs_rd, done_eff ? res : 64'd0, rd_s[exp_g]); end
        checks++; if (obs_exc !== (done_eff ? exc : 1'b1) || obs_to !== !done_eff) begin errors++; $display("FAIL rand%0d_resp_flags got e=%b t=%b exp e=%b t=%b", t, obs_exc, obs_to, done_eff ? exc : 1'b1, !done_eff); end
      end
      mptr = (exp_g + 1) % NR;
    end
  endtask

  initial begin
    for (int r = 0; r < NR; r++) begin
      op_s[r] = '0; fmt_s[r] = '0; a_s[r] = '0; b_s[r] = '0; rd_s[r] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_flush();
    test_collision();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
